load_align_unit: RTL and testbench
==================================

# load_align_unit

Load-side counterpart of the core's shift/store data path. It accepts a load request from the execute stage and issues a word-aligned read to data memory. It waits for the memory acknowledge, then right-shifts and sign- or zero-extends the returned word according to the byte offset and `funct3`, and hands the result to writeback over a valid/ready handshake. It sits between the execute stage and the data-memory port of the RV32I core. It also reports misaligned, illegal-type and timed-out loads.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting for `i_mem_ack` before a timeout fault; legal range 1..255.

- `i_clk`  in  1  clock; all state changes on its rising edge
- `i_rstn`  in  1  reset, synchronous, active-low
- `i_req_valid`  in  1  load request valid
- `o_req_ready`  out  1  unit can accept a request; high only in IDLE
- `i_addr`  in  32  byte address of the load
- `i_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `o_mem_req`  out  1  memory read request, held until acknowledged
- `o_mem_addr`  out  32  word address `{addr[31:2],2'b00}`
- `i_mem_ack`  in  1  memory read data valid this cycle
- `i_mem_rdata`  in  32  memory read word
- `o_rsp_valid`  out  1  response valid
- `i_rsp_ready`  in  1  writeback accepts response
- `o_rsp_data`  out  32  aligned, extended load data
- `o_rsp_fault`  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3

## Operation
- **FSM states:** IDLE, MEM, RESP.
- **Reset** (`i_rstn`=0 at a rising edge):
  - state goes to IDLE and the timeout counter clears.
  - `o_mem_req`=0, `o_mem_addr`=0, `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_fault`=00.
  - `o_req_ready`=1 (decoded from IDLE).
- **Reset mid-operation:** an in-flight request is dropped. An `i_mem_ack` arriving afterwards in IDLE is ignored.
- **IDLE:** a request is accepted when `i_req_valid & o_req_ready`. The unit latches `i_addr` and `i_funct3`.
  - If `i_funct3` ∈ {011, 110, 111}, go to RESP with fault 11 and data 0.
  - Else if the access is misaligned (LH/LHU with `addr[0]`=1, or LW with `addr[1:0]`≠00), go to RESP with fault 01 and data 0.
  - Otherwise go to MEM and clear the counter.
- **MEM:** `o_mem_req`=1 and `o_mem_addr` is held stable.
  - On `i_mem_ack`, register the extracted data with fault 00 and go to RESP.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`, go to RESP with fault 10 and data 0.
  - If `i_mem_ack` arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins.
- **RESP:** `o_rsp_valid`=1; data and fault are held stable until `i_rsp_ready`=1. Then go to IDLE and drop `o_rsp_valid` at the next edge.
- **Extraction:** `sh = i_mem_rdata >> (8*addr[1:0])`.
  - LB: `{{24{sh[7]}},sh[7:0]}`
  - LBU: `{24'b0,sh[7:0]}`
  - LH: `{{16{sh[15]}},sh[15:0]}`
  - LHU: `{16'b0,sh[15:0]}`
  - LW: `sh`
- `i_mem_ack` outside MEM is ignored.
- `i_req_valid` outside IDLE is ignored; requests are not queued.

## Timing
- Request accepted at edge N → `o_mem_req`=1 from cycle N+1.
- `i_mem_ack` sampled at edge M → `o_rsp_valid`=1 from cycle M+1. Minimum request-to-response latency is 2 cycles (ack in the first MEM cycle).
- A fault detected at accept → `o_rsp_valid`=1 at N+1, with no memory request issued.
- Timeout: with no ack, `o_rsp_valid` rises `TIMEOUT`+1 cycles after accept.
- Response handshake at edge K → `o_req_ready`=1 at K+1. Maximum throughput is one load per 3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Test plan
- **Reset:** hold `i_rstn`=0 for 3 cycles with `i_req_valid`=1 → `o_mem_req`=0, `o_rsp_valid`=0, `o_req_ready`=1 after release, and no request accepted during reset.
- **LB sign-extension:** LB at 0x1003, rdata 0x80FF_1234, ack one cycle after `o_mem_req` → `o_mem_addr`=0x1000, data 0xFFFF_FF80, fault 00.
- **LHU/LH extension:** LHU at 0x2002 with rdata 0xBEEF_0001 → 0x0000_BEEF. LH at the same address → 0xFFFF_BEEF.
- **Faults:** LW at 0x2001 → fault 01, data 0, `o_mem_req` never asserted. `funct3`=011 → fault 11.
- **Timeout:** `TIMEOUT`=4, no ack → fault 10 and `o_rsp_valid` at accept+5. A late ack is ignored. A second run with the ack on the 4th wait cycle → fault 00.
- **Backpressure:** hold `i_rsp_ready`=0 for 5 cycles → data stable, `o_req_ready`=0 throughout. Back-to-back loads after the handshake are accepted at K+1.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: accepts a load from execute, issues a word-aligned read to
// data memory, then aligns and extends the returned word for writeback.
// Misaligned accesses, unsupported funct3 codes and missing acknowledges are
// reported as faults instead of data.
module load_align_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [1:0]  o_rsp_fault
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] FLT_OK    = 2'b00;
  localparam logic [1:0] FLT_MISAL = 2'b01;
  localparam logic [1:0] FLT_TMO   = 2'b10;
  localparam logic [1:0] FLT_ILL   = 2'b11;

  // TIMEOUT is limited to 1..255, so an 8-bit wait counter never wraps.
  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  logic [1:0]  state_q,     state_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic [1:0]  off_q,       off_d;
  logic [2:0]  funct3_q,    funct3_d;
  logic        mem_req_q,   mem_req_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q,  rsp_data_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic [7:0]  cnt_inc_s;
  logic        illegal_s;
  logic        misaligned_s;

  // Shift the selected byte/halfword down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = sh;
      3'b100:  res = {24'd0, sh[7:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Classify the incoming request: unsupported type, or misaligned for its size.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    case (i_funct3)
      3'b000, 3'b100: misaligned_s = 1'b0;
      3'b001, 3'b101: misaligned_s = i_addr[0];
      3'b010:         misaligned_s = (i_addr[1:0] != 2'b00);
      default:        illegal_s    = 1'b1;
    endcase
  end

  assign cnt_inc_s = cnt_q + 8'd1;

  // Next-state logic for the IDLE -> MEM -> RESP load sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          off_d    = i_addr[1:0];
          funct3_d = i_funct3;
          if (illegal_s) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = FLT_ILL;
            rsp_data_d  = 32'd0;
          end else if (misaligned_s) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = FLT_MISAL;
            rsp_data_d  = 32'd0;
          end else begin
            state_d    = ST_MEM;
            mem_req_d  = 1'b1;
            mem_addr_d = {i_addr[31:2], 2'b00};
            cnt_d      = 8'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (i_mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = FLT_OK;
          rsp_data_d  = extract_load(i_mem_rdata, off_q, funct3_q);
        end else if (cnt_inc_s == TIMEOUT_C) begin
          state_d     = ST_RESP;
          cnt_d       = cnt_inc_s;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = FLT_TMO;
          rsp_data_d  = 32'd0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_req_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      off_q       <= 2'd0;
      funct3_q    <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_fault_q <= FLT_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (TIMEOUT=4): extension, faults,
// timeout, reset, backpressure and back-to-back acceptance.
module tb_load_align_unit;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_fault;

  int total;
  int bad;

  load_align_unit #(.TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_addr      (addr),
    .i_funct3    (funct3),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_fault (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] a, input logic [2:0] f);
    req_valid = 1'b1;
    addr      = a;
    funct3    = f;
  endtask

  task automatic handshake();
    mem_ack   = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    req_valid = 1'b1;
    addr      = 32'h0000_1003;
    funct3    = 3'b000;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    rsp_ready = 1'b0;

    // Reset held 3 cycles with a request pending.
    tick(); tick(); tick();
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    chk("rst_fault",     32'(rsp_fault), 32'd0);
    req_valid = 1'b0;
    rstn      = 1'b1;
    tick();
    chk("post_rst_mem_req", 32'(mem_req),   32'd0);
    chk("post_rst_ready",   32'(req_ready), 32'd1);

    // LB at 0x1003, ack one cycle after mem_req.
    present(32'h0000_1003, 3'b000);
    tick();
    req_valid = 1'b0;
    chk("lb_mem_req",  32'(mem_req),   32'd1);
    chk("lb_mem_addr", mem_addr,       32'h0000_1000);
    chk("lb_ready",    32'(req_ready), 32'd0);
    tick();
    chk("lb_wait_valid", 32'(rsp_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h80FF_1234;
    tick();
    mem_ack = 1'b0;
    chk("lb_valid", 32'(rsp_valid), 32'd1);
    chk("lb_data",  rsp_data,       32'hFFFF_FF80);
    chk("lb_fault", 32'(rsp_fault), 32'd0);
    chk("lb_mreq_drop", 32'(mem_req), 32'd0);
    handshake();
    chk("lb_hs_valid", 32'(rsp_valid), 32'd0);
    chk("lb_hs_ready", 32'(req_ready), 32'd1);

    // LHU at 0x2002, ack in the first MEM cycle (latency 2).
    present(32'h0000_2002, 3'b101);
    tick();
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBEEF_0001;
    tick();
    chk("lhu_valid", 32'(rsp_valid), 32'd1);
    chk("lhu_data",  rsp_data,       32'h0000_BEEF);
    handshake();

    // LH at the same address.
    present(32'h0000_2002, 3'b001);
    tick();
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    tick();
    chk("lh_data",  rsp_data,       32'hFFFF_BEEF);
    chk("lh_fault", 32'(rsp_fault), 32'd0);
    handshake();

    // LBU at 0x3001 and LW at 0x3000.
    present(32'h0000_3001, 3'b100);
    tick();
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    chk("lbu_data", rsp_data, 32'h0000_0056);
    handshake();
    present(32'h0000_3000, 3'b010);
    tick();
    req_valid = 1'b0;
    chk("lw_mem_addr", mem_addr, 32'h0000_3000);
    mem_ack = 1'b1;
    tick();
    chk("lw_data", rsp_data, 32'h1234_5678);
    handshake();

    // Misaligned LW: immediate fault, no memory request.
    present(32'h0000_2001, 3'b010);
    tick();
    req_valid = 1'b0;
    chk("mis_valid",   32'(rsp_valid), 32'd1);
    chk("mis_fault",   32'(rsp_fault), 32'd1);
    chk("mis_data",    rsp_data,       32'd0);
    chk("mis_mem_req", 32'(mem_req),   32'd0);
    handshake();

    // Illegal funct3.
    present(32'h0000_0000, 3'b011);
    tick();
    req_valid = 1'b0;
    chk("ill_valid",   32'(rsp_valid), 32'd1);
    chk("ill_fault",   32'(rsp_fault), 32'd3);
    chk("ill_data",    rsp_data,       32'd0);
    chk("ill_mem_req", 32'(mem_req),   32'd0);
    handshake();

    // Timeout: no ack, response after TIMEOUT MEM cycles.
    present(32'h0000_4000, 3'b010);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("tmo_wait_valid", 32'(rsp_valid), 32'd0);
    chk("tmo_wait_req",   32'(mem_req),   32'd1);
    tick();
    chk("tmo_valid",   32'(rsp_valid), 32'd1);
    chk("tmo_fault",   32'(rsp_fault), 32'd2);
    chk("tmo_data",    rsp_data,       32'd0);
    chk("tmo_mem_req", 32'(mem_req),   32'd0);
    // Late ack in RESP is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("late_fault", 32'(rsp_fault), 32'd2);
    chk("late_data",  rsp_data,       32'd0);
    handshake();
    // Ack in IDLE is ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ack_req",   32'(mem_req),   32'd0);

    // Ack on the 4th wait cycle wins over the timeout.
    present(32'h0000_4000, 3'b010);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("ack4_fault", 32'(rsp_fault), 32'd0);
    chk("ack4_data",  rsp_data,       32'hCAFE_F00D);
    handshake();

    // Reset mid-operation drops the request; later ack is ignored.
    present(32'h0000_1003, 3'b000);
    tick();
    req_valid = 1'b0;
    rstn      = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_mem_req", 32'(mem_req),   32'd0);
    chk("midrst_ready",   32'(req_ready), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("midrst_ack_valid", 32'(rsp_valid), 32'd0);

    // Backpressure: response held for 5 cycles, requests ignored meanwhile.
    present(32'h0000_5004, 3'b010);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_BEEF;
    present(32'h0000_6002, 3'b101);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h7777_8888;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  rsp_data,       32'h0BAD_BEEF);
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    chk("bp_no_mem_req", 32'(mem_req), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("b2b_hs_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_hs_ready", 32'(req_ready), 32'd1);
    chk("b2b_hs_mreq",  32'(mem_req),   32'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b_mem_req",  32'(mem_req), 32'd1);
    chk("b2b_mem_addr", mem_addr,     32'h0000_6000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_data", rsp_data, 32'h0000_7777);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
